toysram_16x12_ctl: RTL and testbench
====================================

Name: toysram_16x12_ctl

Overview:
- Synchronous port controller sitting directly upstream of the 16x12 toysram subarray, and consuming the subarray's read bitlines.
- Turns two clocked read requests and one write request per cycle into one-hot read wordlines (RWL0/RWL1), a timed write-wordline pulse (WWL) and differential write bitlines (WBL/WBLb).
- Captures the active-low read bitlines and returns true-polarity registered read data.

Parameters:
- WSETUP, 1, cycles WBL/WBLb are driven before WWL rises (1..3)
- WPULSE, 1, cycles WWL is held high (1..3)
- WHOLD, 1, cycles WBL/WBLb are held after WWL falls (1..3)

Ports:
- clk  in  1  sole clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd0_en  in  1  read port 0 request
- rd0_adr  in  4  read port 0 row
- rd0_val  out  1  read port 0 data valid
- rd0_dat  out  12  read port 0 data
- rd1_en, rd1_adr, rd1_val, rd1_dat: same as port 0, for port 1
- wr_val  in  1  write request
- wr_rdy  out  1  controller can accept a write
- wr_adr  in  4  write row
- wr_dat  in  12  write data
- RWL0  out  16  read wordlines port 0, one-hot or zero, registered
- RWL1  out  16  read wordlines port 1, one-hot or zero, registered
- WWL  out  16  write wordlines, one-hot or zero, registered
- WBL  out  12  write bitline true, registered
- WBLb  out  12  write bitline complement, registered
- RBL0  in  12  subarray read bitlines port 0, active-low
- RBL1  in  12  subarray read bitlines port 1, active-low

Behaviour:
- Reset (async assert, sync deassert handled externally): RWL0=RWL1=WWL=0, WBL=0, WBLb=12'hFFF, rdN_val=0, rdN_dat=0, wr_rdy=1, FSM=IDLE, phase counter=0.
- Read pipeline (ports independent, identical):
  - cycle N: rdN_en=1 sampled.
  - cycle N+1: RWLN = onehot(rdN_adr); the subarray evaluates RBLN combinationally.
  - edge ending N+1: rdN_dat <= ~RBLN and rdN_val <= 1.
  - Latency 2, throughput 1 per cycle per port.
  - rdN_en=0 gives RWLN=0 the next cycle and rdN_val=0 one cycle later; rdN_dat holds its last value.
- Both ports may read the same row in the same cycle. Each returns identical data.
- Write FSM states: IDLE, SETUP, PULSE, HOLD. A 2-bit phase counter counts within each state.
  - IDLE: wr_rdy=1. wr_val=1 at an edge latches wr_adr/wr_dat and moves to SETUP. wr_rdy=0 from the next cycle.
  - SETUP (WSETUP cycles): WBL=dat, WBLb=~dat, WWL=0.
  - PULSE (WPULSE cycles): WWL=onehot(adr); WBL/WBLb unchanged.
  - HOLD (WHOLD cycles): WWL=0; WBL/WBLb unchanged. Then IDLE, with WBL=0 and WBLb=12'hFFF.
  - Write period at defaults: 4 cycles (accept + 3). wr_val while wr_rdy=0 is ignored; no queueing.
  - WWL is never asserted outside PULSE, and at most one bit is ever set.
- Read/write ordering: the subarray latches on the WWL rising edge.
  - A read whose RWL cycle falls in the first PULSE cycle or later returns the new data.
  - An earlier read returns the old data.
  - No forwarding logic.
- Reset mid-write: WWL drops immediately and the write is abandoned.
  - If PULSE had begun, the row holds the new data; otherwise the row is unchanged.
  - Reads in flight are discarded; rdN_val=0.
- Rows never written return undefined data. The controller does not track this.
- Simulation-only assertions:
  - RWL0, RWL1 and WWL are each one-hot or zero.
  - WBL^WBLb is all-ones whenever WWL is nonzero.

Decomposition:
- Package toysram_pkg holds:
  - constants ROWS=16, BITS=12, ADR_W=4.
  - write FSM state encoding (IDLE=0, SETUP=1, PULSE=2, HOLD=3).
- Sub-module toysram_dec4x16 (en, adr[0:3] to one-hot[0:15]) is instantiated three times, for RWL0, RWL1 and WWL.
- Bit order is [0:N] throughout. Row k drives wordline bit k.

Test Plan:
- Reset, then write row 5 = 12'hA5C: WBL=A5C and WBLb=5A3 from cycle 1; WWL[5] high only in cycle 2; wr_rdy=0 for cycles 1-3 and 1 again in cycle 4.
- After that write, read port 0 row 5 and port 1 row 5 in the same cycle: both rdN_val=1 two cycles later, rd0_dat=rd1_dat=A5C.
- Write row 3 = FFF, then row 3 = 000. Issue port-0 reads of row 3 so their RWL cycles land in SETUP and in PULSE: the SETUP read returns FFF, the PULSE read returns 000.
- Back-to-back port-1 reads of rows 0..15 (rows pre-written with value = row*0x111): valid every cycle from cycle 2; data sequence 000,111,...,FFF.
- wr_val held high for 10 cycles at defaults: exactly 3 writes accepted, at cycles 0, 4 and 8; WWL pulses at cycles 2, 6 and 10.
- Assert rst_n=0 during the PULSE of a write to row 9 with a read pending: WWL, RWL and rdN_val go to 0 immediately, wr_rdy=1. A later read of row 9 returns the new data.

Source files
------------

// File: rtl/toysram_pkg.sv
// ----------------------------------------------------------------------------
// toysram_pkg
//   Shared constants and the write-FSM state encoding for the 16x12 toysram
//   port controller and its wordline decoder.
//   Contents:
//     ROWS, BITS, ADR_W : geometry of the subarray (16 rows of 12 bits)
//     wr_state_e        : write FSM states IDLE/SETUP/PULSE/HOLD (0..3)
// ----------------------------------------------------------------------------
package toysram_pkg;

   localparam int ROWS  = 16;
   localparam int BITS  = 12;
   localparam int ADR_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_PULSE = 2'd2,
      ST_HOLD  = 2'd3
   } wr_state_e;

endpackage

// File: rtl/toysram_dec4x16.sv
// ----------------------------------------------------------------------------
// toysram_dec4x16
//   Combinational 4-to-16 wordline decoder. Output is all-zero when en=0,
//   otherwise exactly bit adr is set (row k drives wordline bit k).
//   Ports:
//     en     in   1   decode enable
//     adr    in   4   row address, [0:3]
//     onehot out  16  one-hot or zero wordline pattern, [0:15]
// ----------------------------------------------------------------------------
module toysram_dec4x16
   import toysram_pkg::*;
(
   input  logic             en,
   input  logic [0:ADR_W-1] adr,
   output logic [0:ROWS-1]  onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[adr] = 1'b1;
      end
   end

endmodule

// File: rtl/toysram_16x12_ctl.sv
// ----------------------------------------------------------------------------
// toysram_16x12_ctl
//   Port controller for the 16x12 toysram subarray. Two independent read
//   ports drive registered one-hot read wordlines and capture the active-low
//   read bitlines one cycle later (latency 2, one read per cycle per port).
//   One write port runs a SETUP/PULSE/HOLD sequence that drives the
//   differential write bitlines around a single registered WWL pulse.
//
//   Handshake: a write is accepted on a rising edge where wr_val=1 and
//   wr_rdy=1. wr_rdy is high only while the write FSM is IDLE; wr_val while
//   wr_rdy=0 is ignored (no queueing). Reads have no backpressure: each
//   rdN_en=1 produces rdN_val=1 exactly two cycles later.
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     rd0_en/rd0_adr       read port 0 request / row
//     rd0_val/rd0_dat      read port 0 data valid / true-polarity data
//     rd1_*                same for read port 1
//     wr_val/wr_rdy        write request / controller can accept
//     wr_adr/wr_dat        write row / data
//     RWL0, RWL1, WWL      registered wordlines (one-hot or zero)
//     WBL, WBLb            registered differential write bitlines
//     RBL0, RBL1           subarray read bitlines, active-low
// ----------------------------------------------------------------------------
module toysram_16x12_ctl
   import toysram_pkg::*;
#(
   parameter int WSETUP = 1,
   parameter int WPULSE = 1,
   parameter int WHOLD  = 1
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rd0_en,
   input  logic [0:ADR_W-1] rd0_adr,
   output logic             rd0_val,
   output logic [0:BITS-1]  rd0_dat,
   input  logic             rd1_en,
   input  logic [0:ADR_W-1] rd1_adr,
   output logic             rd1_val,
   output logic [0:BITS-1]  rd1_dat,
   input  logic             wr_val,
   output logic             wr_rdy,
   input  logic [0:ADR_W-1] wr_adr,
   input  logic [0:BITS-1]  wr_dat,
   output logic [0:ROWS-1]  RWL0,
   output logic [0:ROWS-1]  RWL1,
   output logic [0:ROWS-1]  WWL,
   output logic [0:BITS-1]  WBL,
   output logic [0:BITS-1]  WBLb,
   input  logic [0:BITS-1]  RBL0,
   input  logic [0:BITS-1]  RBL1
);

   localparam logic [1:0] SETUP_LAST = 2'(WSETUP - 1);
   localparam logic [1:0] PULSE_LAST = 2'(WPULSE - 1);
   localparam logic [1:0] HOLD_LAST  = 2'(WHOLD - 1);

   // Write FSM state (observable by name for checkers)
   wr_state_e        wr_state_q, wr_state_d;
   logic [1:0]       phase_q, phase_d;
   logic [0:ADR_W-1] adr_q, adr_d;
   logic [0:BITS-1]  dat_q, dat_d;

   logic [0:ROWS-1]  rwl0_d, rwl1_d, wwl_d;
   logic [0:BITS-1]  wbl_d, wblb_d;
   logic             rd0_pend_q, rd1_pend_q;

   // ---------------------------------------------------------------------
   // Write FSM: next state, phase counter and latched request
   // ---------------------------------------------------------------------
   always_comb begin
      wr_state_d = wr_state_q;
      phase_d    = phase_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      wr_rdy     = 1'b0;
      case (wr_state_q)
         ST_IDLE: begin
            wr_rdy = 1'b1;
            if (wr_val) begin
               wr_state_d = ST_SETUP;
               phase_d    = 2'd0;
               adr_d      = wr_adr;
               dat_d      = wr_dat;
            end
         end
         ST_SETUP: begin
            if (phase_q == SETUP_LAST) begin
               wr_state_d = ST_PULSE;
               phase_d    = 2'd0;
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         ST_PULSE: begin
            if (phase_q == PULSE_LAST) begin
               wr_state_d = ST_HOLD;
               phase_d    = 2'd0;
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         ST_HOLD: begin
            if (phase_q == HOLD_LAST) begin
               wr_state_d = ST_IDLE;
               phase_d    = 2'd0;
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         default: begin
            wr_state_d = ST_IDLE;
            phase_d    = 2'd0;
         end
      endcase
   end

   // Bitlines and WWL are registered from next-state values so they change
   // on the same edge the FSM enters the corresponding state.
   always_comb begin
      wbl_d  = '0;
      wblb_d = '1;
      if (wr_state_d != ST_IDLE) begin
         wbl_d  = dat_d;
         wblb_d = ~dat_d;
      end
   end

   toysram_dec4x16 u_dec_wwl (
      .en     (wr_state_d == ST_PULSE),
      .adr    (adr_d),
      .onehot (wwl_d)
   );

   toysram_dec4x16 u_dec_rwl0 (
      .en     (rd0_en),
      .adr    (rd0_adr),
      .onehot (rwl0_d)
   );

   toysram_dec4x16 u_dec_rwl1 (
      .en     (rd1_en),
      .adr    (rd1_adr),
      .onehot (rwl1_d)
   );

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q <= ST_IDLE;
         phase_q    <= 2'd0;
         adr_q      <= '0;
         dat_q      <= '0;
         WWL        <= '0;
         WBL        <= '0;
         WBLb       <= '1;
      end else begin
         wr_state_q <= wr_state_d;
         phase_q    <= phase_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         WWL        <= wwl_d;
         WBL        <= wbl_d;
         WBLb       <= wblb_d;
      end
   end

   // Read pipeline: rdN_pend_q marks a cycle in which RWLN is driven, so the
   // bitlines are valid to capture at the end of that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RWL0       <= '0;
         RWL1       <= '0;
         rd0_pend_q <= 1'b0;
         rd1_pend_q <= 1'b0;
         rd0_val    <= 1'b0;
         rd1_val    <= 1'b0;
         rd0_dat    <= '0;
         rd1_dat    <= '0;
      end else begin
         RWL0       <= rwl0_d;
         RWL1       <= rwl1_d;
         rd0_pend_q <= rd0_en;
         rd1_pend_q <= rd1_en;
         rd0_val    <= rd0_pend_q;
         rd1_val    <= rd1_pend_q;
         if (rd0_pend_q) begin
            rd0_dat <= ~RBL0;
         end
         if (rd1_pend_q) begin
            rd1_dat <= ~RBL1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Simulation-only properties
   // ---------------------------------------------------------------------
   a_rwl0_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(RWL0));
   a_rwl1_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(RWL1));
   a_wwl_onehot  : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(WWL));
   a_wbl_diff    : assert property (@(posedge clk) disable iff (!rst_n)
                                    (WWL != '0) |-> ((WBL ^ WBLb) == '1));

endmodule

// File: tb/tb_toysram_16x12_ctl.sv
// ----------------------------------------------------------------------------
// tb_toysram_16x12_ctl
//   Bench for toysram_16x12_ctl with a behavioural subarray: rows latch WBL
//   on the WWL rising edge, read bitlines are active-low and all-ones when no
//   read wordline is driven.
// ----------------------------------------------------------------------------
module tb_toysram_16x12_ctl;

   logic        clk;
   logic        rst_n;
   logic        rd0_en, rd1_en;
   logic [0:3]  rd0_adr, rd1_adr;
   logic        rd0_val, rd1_val;
   logic [0:11] rd0_dat, rd1_dat;
   logic        wr_val, wr_rdy;
   logic [0:3]  wr_adr;
   logic [0:11] wr_dat;
   logic [0:15] RWL0, RWL1, WWL;
   logic [0:11] WBL, WBLb;
   logic [0:11] RBL0, RBL1;

   int n_vec;
   int n_err;

   logic [11:0] exp0_q[$];
   logic [11:0] exp1_q[$];
   logic [15:0] wexp_q[$];   // {row[3:0], data[11:0]}

   toysram_16x12_ctl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd0_en  (rd0_en),
      .rd0_adr (rd0_adr),
      .rd0_val (rd0_val),
      .rd0_dat (rd0_dat),
      .rd1_en  (rd1_en),
      .rd1_adr (rd1_adr),
      .rd1_val (rd1_val),
      .rd1_dat (rd1_dat),
      .wr_val  (wr_val),
      .wr_rdy  (wr_rdy),
      .wr_adr  (wr_adr),
      .wr_dat  (wr_dat),
      .RWL0    (RWL0),
      .RWL1    (RWL1),
      .WWL     (WWL),
      .WBL     (WBL),
      .WBLb    (WBLb),
      .RBL0    (RBL0),
      .RBL1    (RBL1)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- subarray model ----------------
   logic [0:11] mem [0:15];
   logic [0:15] wwl_seen;
   initial wwl_seen = '0;

   always @(WWL) begin
      if (wwl_seen == '0) begin
         for (int k = 0; k < 16; k++) begin
            if (WWL[k]) mem[k] = WBL;
         end
      end
      wwl_seen = WWL;
   end

   always_comb begin
      RBL0 = '1;
      RBL1 = '1;
      for (int k = 0; k < 16; k++) begin
         if (RWL0[k]) RBL0 = ~mem[k];
         if (RWL1[k]) RBL1 = ~mem[k];
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] onehot16(input int row);
      logic [0:15] v;
      v = '0;
      v[row] = 1'b1;
      return 16'(v);
   endfunction

   task automatic wait_rdy();
      int n;
      n = 0;
      while (!wr_rdy && n < 20) begin
         tick();
         n++;
      end
      if (!wr_rdy) chk("wr_rdy_timeout", {15'd0, wr_rdy}, 16'd1);
   endtask

   task automatic do_write(input int row, input logic [11:0] dat);
      wait_rdy();
      wr_val = 1'b1;
      wr_adr = 4'(row);
      wr_dat = dat;
      wexp_q.push_back({4'(row), dat});
      tick();
      wr_val = 1'b0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [0:15] wwl_prev;
   initial wwl_prev = '0;

   always @(negedge clk) begin
      logic [11:0] e;
      logic [15:0] w;
      if (rd0_val) begin
         if (exp0_q.size() == 0) begin
            chk("rd0_unexpected_val", {15'd0, rd0_val}, 16'd0);
         end else begin
            e = exp0_q.pop_front();
            chk("rd0_dat", {4'd0, rd0_dat}, {4'd0, e});
         end
      end
      if (rd1_val) begin
         if (exp1_q.size() == 0) begin
            chk("rd1_unexpected_val", {15'd0, rd1_val}, 16'd0);
         end else begin
            e = exp1_q.pop_front();
            chk("rd1_dat", {4'd0, rd1_dat}, {4'd0, e});
         end
      end
      if (WWL != '0 && wwl_prev == '0) begin
         if (wexp_q.size() == 0) begin
            chk("wwl_unexpected", 16'(WWL), 16'd0);
         end else begin
            w = wexp_q.pop_front();
            chk("wwl_row", 16'(WWL), onehot16(int'(w[15:12])));
            chk("wbl_at_pulse", {4'd0, WBL}, {4'd0, w[11:0]});
         end
      end
      wwl_prev = WWL;
   end

   // ---------------- stimulus ----------------
   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      rd0_en  = 1'b0;
      rd1_en  = 1'b0;
      rd0_adr = '0;
      rd1_adr = '0;
      wr_val  = 1'b0;
      wr_adr  = '0;
      wr_dat  = '0;
      tick();
      tick();

      // reset state
      chk("rst_rwl0",    16'(RWL0), 16'h0000);
      chk("rst_rwl1",    16'(RWL1), 16'h0000);
      chk("rst_wwl",     16'(WWL),  16'h0000);
      chk("rst_wbl",     {4'd0, WBL},  16'h0000);
      chk("rst_wblb",    {4'd0, WBLb}, 16'h0FFF);
      chk("rst_wr_rdy",  {15'd0, wr_rdy}, 16'd1);
      chk("rst_rd_val",  {14'd0, rd0_val, rd1_val}, 16'd0);
      chk("rst_rd0_dat", {4'd0, rd0_dat}, 16'h0000);
      rst_n = 1'b1;
      tick();

      // 1: write row 5 = A5C, cycle by cycle
      wr_val = 1'b1;
      wr_adr = 4'd5;
      wr_dat = 12'hA5C;
      chk("t1_c0_rdy", {15'd0, wr_rdy}, 16'd1);
      wexp_q.push_back({4'd5, 12'hA5C});
      tick();
      wr_val = 1'b0;
      chk("t1_c1_wbl",  {4'd0, WBL},  16'h0A5C);
      chk("t1_c1_wblb", {4'd0, WBLb}, 16'h05A3);
      chk("t1_c1_wwl",  16'(WWL), 16'h0000);
      chk("t1_c1_rdy",  {15'd0, wr_rdy}, 16'd0);
      tick();
      chk("t1_c2_wwl",  16'(WWL), onehot16(5));
      chk("t1_c2_rdy",  {15'd0, wr_rdy}, 16'd0);
      tick();
      chk("t1_c3_wwl",  16'(WWL), 16'h0000);
      chk("t1_c3_wbl",  {4'd0, WBL}, 16'h0A5C);
      chk("t1_c3_rdy",  {15'd0, wr_rdy}, 16'd0);
      tick();
      chk("t1_c4_rdy",  {15'd0, wr_rdy}, 16'd1);
      chk("t1_c4_wbl",  {4'd0, WBL},  16'h0000);
      chk("t1_c4_wblb", {4'd0, WBLb}, 16'h0FFF);

      // 2: both ports read row 5 in the same cycle
      rd0_en = 1'b1; rd0_adr = 4'd5;
      rd1_en = 1'b1; rd1_adr = 4'd5;
      exp0_q.push_back(12'hA5C);
      exp1_q.push_back(12'hA5C);
      tick();
      rd0_en = 1'b0;
      rd1_en = 1'b0;
      chk("t2_rwl0", 16'(RWL0), onehot16(5));
      chk("t2_rwl1", 16'(RWL1), onehot16(5));
      chk("t2_val_early", {14'd0, rd0_val, rd1_val}, 16'd0);
      tick();
      chk("t2_val", {14'd0, rd0_val, rd1_val}, 16'd3);
      tick();
      chk("t2_val_drop", {14'd0, rd0_val, rd1_val}, 16'd0);

      // 3: read/write ordering on row 3
      do_write(3, 12'hFFF);
      wait_rdy();
      wr_val  = 1'b1; wr_adr = 4'd3; wr_dat = 12'h000;
      wexp_q.push_back({4'd3, 12'h000});
      rd0_en  = 1'b1; rd0_adr = 4'd3;
      exp0_q.push_back(12'hFFF);     // RWL lands in SETUP
      tick();
      wr_val  = 1'b0;
      exp0_q.push_back(12'h000);     // RWL lands in first PULSE cycle
      tick();
      rd0_en  = 1'b0;
      repeat (3) tick();

      // 4: pre-write rows with row*0x111, then stream port-1 reads
      for (int r = 0; r < 16; r++) begin
         do_write(r, 12'(r * 12'h111));
      end
      wait_rdy();
      for (int c = 0; c < 16; c++) begin
         rd1_en  = 1'b1;
         rd1_adr = 4'(c);
         exp1_q.push_back(12'(c * 12'h111));
         if (c >= 2) chk("t4_val_stream", {15'd0, rd1_val}, 16'd1);
         tick();
      end
      rd1_en = 1'b0;
      chk("t4_val_c16", {15'd0, rd1_val}, 16'd1);
      tick();
      chk("t4_val_c17", {15'd0, rd1_val}, 16'd1);
      tick();
      chk("t4_val_c18", {15'd0, rd1_val}, 16'd0);

      // 5: wr_val held high for 10 cycles
      wait_rdy();
      for (int c = 0; c < 12; c++) begin
         wr_val = (c < 10);
         wr_adr = 4'(c);
         wr_dat = 12'(12'h100 + c);
         if (c == 0 || c == 4 || c == 8) begin
            wexp_q.push_back({4'(c), 12'(12'h100 + c)});
         end
         chk("t5_wwl_active", {15'd0, (WWL != '0)},
             {15'd0, (c == 2 || c == 6 || c == 10)});
         tick();
      end
      wr_val = 1'b0;

      // 6: reset during the PULSE of a write to row 9 with a read pending
      wait_rdy();
      wr_val = 1'b1; wr_adr = 4'd9; wr_dat = 12'h9C3;
      tick();
      wr_val = 1'b0;
      rd0_en = 1'b1; rd0_adr = 4'd2;
      tick();
      rd0_en = 1'b0;
      chk("t6_pulse", 16'(WWL), onehot16(9));
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_wwl",  16'(WWL),  16'h0000);
      chk("t6_rst_rwl0", 16'(RWL0), 16'h0000);
      chk("t6_rst_val",  {14'd0, rd0_val, rd1_val}, 16'd0);
      chk("t6_rst_rdy",  {15'd0, wr_rdy}, 16'd1);
      @(negedge clk);
      chk("t6_rst_val_neg", {15'd0, rd0_val}, 16'd0);
      rst_n = 1'b1;
      tick();
      rd0_en = 1'b1; rd0_adr = 4'd9;
      rd1_en = 1'b1; rd1_adr = 4'd9;
      exp0_q.push_back(12'h9C3);
      exp1_q.push_back(12'h9C3);
      tick();
      rd0_en = 1'b0;
      rd1_en = 1'b0;
      repeat (4) tick();

      // every expected response consumed
      chk("end_exp0_left", 16'(exp0_q.size()), 16'd0);
      chk("end_exp1_left", 16'(exp1_q.size()), 16'd0);
      chk("end_wexp_left", 16'(wexp_q.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
